ysyx_23060096_lsu: RTL and testbench

Load/store unit that consumes the memory-control fields produced by the instruction decoder (MemWr, MemOP) together with the ALU-computed address and the store data, and executes them on the data-memory bus. It sits between the execute stage and writeback. It performs one transaction at a time through a registered FSM, aligns the bytes in both directions, and returns sign- or zero-extended load data to writeback.

---
 rtl/ysyx_23060096_lsu.sv | 168 ++++++++++++++++
 tb/tb_ysyx_23060096_lsu.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060096_lsu.sv
// ysyx_23060096_lsu: single-outstanding load/store unit.
// Byte-lane alignment both ways, sign/zero extension on loads.
module ysyx_23060096_lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_memwr,
  input  logic [2:0]      in_memop,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_mwdata;
  logic [XLEN-1:0] r_rdata;
  logic [3:0]      r_wstrb;
  logic            r_memwr;
  logic [2:0]      r_memop;
  logic            r_err;

  logic            w_hs;
  logic            w_illegal;
  logic [1:0]      w_off;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ldata;

  assign w_hs  = in_valid && (r_state == S_IDLE);
  assign w_off = in_addr[1:0];

  // Flag reserved codes, unsigned stores and misaligned halves/words.
  always_comb begin
    w_illegal = 1'b0;
    unique case (in_memop)
      3'b000:  w_illegal = 1'b0;
      3'b001:  w_illegal = in_addr[0];
      3'b010:  w_illegal = |in_addr[1:0];
      3'b100:  w_illegal = in_memwr;
      3'b101:  w_illegal = in_memwr | in_addr[0];
      default: w_illegal = 1'b1;
    endcase
  end

  // Replicate store data across lanes and build the byte strobe.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = in_wdata;
    if (in_memwr) begin
      unique case (in_memop[1:0])
        2'b00: begin
          w_wstrb = 4'b0001 << w_off;
          w_wdata = {4{in_wdata[7:0]}};
        end
        2'b01: begin
          w_wstrb = 4'b0011 << w_off;
          w_wdata = {2{in_wdata[15:0]}};
        end
        default: w_wstrb = 4'b1111;
      endcase
    end
  end

  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = mem_rdata[{r_addr[1], 4'b0000} +: 16];

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    w_ldata = mem_rdata;
    unique case (r_memop)
      3'b000:  w_ldata = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_ldata = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_ldata = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_ldata = {{(XLEN-16){1'b0}}, w_half};
      default: w_ldata = mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state and handshake strobes.
  always_comb begin
    w_next        = r_state;
    in_ready      = 1'b0;
    mem_req_valid = 1'b0;
    mem_rsp_ready = 1'b0;
    out_valid     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = w_illegal ? S_DONE : S_REQ;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = S_RESP;
      end
      S_RESP: begin
        mem_rsp_ready = 1'b1;
        if (mem_rsp_valid) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
    endcase
  end

  // Capture the operation on accept, the load result on response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_mwdata <= '0;
      r_wstrb  <= '0;
      r_memwr  <= 1'b0;
      r_memop  <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else if (w_hs) begin
      r_addr   <= in_addr;
      r_mwdata <= w_wdata;
      r_wstrb  <= w_wstrb;
      r_memwr  <= in_memwr;
      r_memop  <= in_memop;
      r_err    <= w_illegal;
      r_rdata  <= '0;
    end else if (r_state == S_RESP && mem_rsp_valid) begin
      r_rdata  <= r_memwr ? '0 : w_ldata;
    end
  end

  assign mem_addr  = (r_state == S_REQ) ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign mem_wen   = (r_state == S_REQ) && r_memwr;
  assign mem_wdata = (r_state == S_REQ) ? r_mwdata : '0;
  assign mem_wstrb = (r_state == S_REQ) ? r_wstrb : 4'b0000;
  assign out_rdata = (r_state == S_DONE) ? r_rdata : '0;
  assign out_err   = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_ysyx_23060096_lsu.sv
// tb_ysyx_23060096_lsu: scoreboard bench with a byte-array memory model.
// Random and directed loads/stores, bus and writeback backpressure, reset abort.
module tb_ysyx_23060096_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_memwr;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_memop;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid, mem_rsp_ready;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  ysyx_23060096_lsu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .in_memwr(in_memwr), .in_memop(in_memop),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata(out_rdata), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  exp_t exp_q[$];
  req_t req_q[$];

  logic [7:0]  ref_mem [0:63];
  logic [31:0] bus_mem [0:15];

  int n_chk = 0;
  int n_fail = 0;

  bit fast = 1'b0;
  bit abort_mode = 1'b0;
  bit lat_mode = 1'b0;
  int prev_hs = -1;
  int cfg_req_stall = 0;
  int cfg_rsp_dly = 0;
  int cfg_out_stall = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h80FF7F01;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
  endfunction

  function automatic int sz_of(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic wr,
                               input logic [2:0] op);
    if (op == 3'd3 || op == 3'd6 || op == 3'd7) return 1'b0;
    if (op[2] && wr) return 1'b0;
    return (int'(a[1:0]) % sz_of(op)) == 0;
  endfunction

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_ctrl"},
        32'({mem_req_valid, mem_wen, mem_wstrb, mem_rsp_ready,
             out_valid, out_err}), 32'd0);
    chk({nm, "_mem_addr"}, mem_addr, 32'd0);
    chk({nm, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({nm, "_out_rdata"}, out_rdata, 32'd0);
  endtask

  // Wait for an idle unit, then change the bus / writeback behaviour.
  task automatic set_cfg(input bit f, input int rs, input int rd,
                         input int os);
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
    fast = f;
    cfg_req_stall = rs;
    cfg_rsp_dly = rd;
    cfg_out_stall = os;
    @(posedge clk);
    #1;
  endtask

  // Present one operation; on accept, push the model's expectations.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic wr, input logic [2:0] op);
    bit ok = 1'b0;
    exp_t e;
    req_t r;
    int off;
    int sz;
    logic [31:0] v;
    in_valid = 1'b1;
    in_addr = a;
    in_wdata = wd;
    in_memwr = wr;
    in_memop = op;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_now("in_ready_timeout");
    end else begin
      off = int'(a[5:0]);
      sz = sz_of(op);
      e.hs = cyc;
      e.rdata = 32'd0;
      e.err = 1'b0;
      if (!legal(a, wr, op)) begin
        e.err = 1'b1;
      end else if (wr) begin
        for (int i = 0; i < sz; i++) ref_mem[off + i] = wd[8*i +: 8];
        r.addr = {a[31:2], 2'b00};
        r.wen = 1'b1;
        if (sz == 1) r.wdata = {24'd0, wd[7:0]} * 32'h01010101;
        else if (sz == 2) r.wdata = {16'd0, wd[15:0]} * 32'h00010001;
        else r.wdata = wd;
        r.wstrb = 4'(((1 << sz) - 1) << int'(a[1:0]));
        req_q.push_back(r);
      end else begin
        v = 32'd0;
        for (int i = 0; i < sz; i++)
          v = v | (32'(ref_mem[off + i]) << (8 * i));
        if (!op[2] && sz < 4 && v[8*sz-1])
          v = v | ((sz == 1) ? 32'hFFFFFF00 : 32'hFFFF0000);
        e.rdata = v;
        r.addr = {a[31:2], 2'b00};
        r.wen = 1'b0;
        r.wdata = 32'd0;
        r.wstrb = 4'b0000;
        req_q.push_back(r);
      end
      e.lat = fast ? (e.err ? 1 : 3) : -1;
      exp_q.push_back(e);
      if (lat_mode) begin
        if (prev_hs >= 0) chk("hs_interval", 32'(cyc - prev_hs), 32'd4);
        prev_hs = cyc;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_addr = $urandom;
    in_wdata = $urandom;
    in_memwr = 1'($urandom);
    in_memop = 3'($urandom);
  endtask

  // Bus responder: word memory with strobes, configurable stalls.
  int          scnt = 0;
  bit          rpend = 1'b0;
  logic [31:0] s_addr, s_wdata, rword;
  logic        s_wen;
  logic [3:0]  s_wstrb;
  bit          got;
  req_t        rq;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = 32'd0;
    for (int i = 0; i < 16; i++) bus_mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      #1;
      mem_req_ready = fast || (scnt >= cfg_req_stall);
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        if (rpend) begin
          chk("mem_addr_hold", mem_addr, s_addr);
          chk("mem_wen_hold", 32'(mem_wen), 32'(s_wen));
          chk("mem_wdata_hold", mem_wdata, s_wdata);
          chk("mem_wstrb_hold", 32'(mem_wstrb), 32'(s_wstrb));
        end
        if (!mem_req_ready) begin
          scnt++;
          rpend = 1'b1;
          s_addr = mem_addr;
          s_wen = mem_wen;
          s_wdata = mem_wdata;
          s_wstrb = mem_wstrb;
        end else begin
          rpend = 1'b0;
          scnt = 0;
          if (req_q.size() == 0) begin
            fail_now("unexpected_req");
          end else begin
            rq = req_q.pop_front();
            chk("mem_addr", mem_addr, rq.addr);
            chk("mem_wen", 32'(mem_wen), 32'(rq.wen));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(rq.wstrb));
            if (rq.wen) chk("mem_wdata", mem_wdata, rq.wdata);
          end
          if (mem_wen) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b])
                bus_mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            rword = $urandom;
          end else begin
            rword = bus_mem[mem_addr[5:2]];
          end
          @(posedge clk);
          #1;
          mem_req_ready = 1'b0;
          for (int k = 0; k < (fast ? 0 : cfg_rsp_dly); k++) begin
            @(posedge clk);
            #1;
          end
          mem_rsp_valid = 1'b1;
          mem_rdata = rword;
          got = 1'b0;
          for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (mem_rsp_ready) begin
              got = 1'b1;
            end else begin
              @(posedge clk);
              #1;
            end
          end
          if (!abort_mode) chk("rsp_accepted", 32'(got), 32'd1);
          if (got) begin
            @(posedge clk);
            #1;
          end
          mem_rsp_valid = 1'b0;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Writeback monitor: drives out_ready, pops and compares results.
  int          ocnt = 0;
  bit          opend = 1'b0;
  logic [31:0] so_rdata;
  logic        so_err;
  exp_t        ex;

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = fast || (ocnt >= cfg_out_stall);
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (opend) begin
          chk("out_rdata_hold", out_rdata, so_rdata);
          chk("out_err_hold", 32'(out_err), 32'(so_err));
        end
        if (!out_ready) begin
          ocnt++;
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
          opend = 1'b1;
          so_rdata = out_rdata;
          so_err = out_err;
        end else begin
          ocnt = 0;
          opend = 1'b0;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_out");
          end else begin
            ex = exp_q.pop_front();
            chk("out_rdata", out_rdata, ex.rdata);
            chk("out_err", 32'(out_err), 32'(ex.err));
            if (ex.lat >= 0)
              chk("out_latency", 32'(cyc - ex.hs), 32'(ex.lat));
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    bit ok;
    int sz;
    int off;
    logic [2:0] op;
    logic wr;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_addr = 32'd0;
    in_wdata = 32'd0;
    in_memwr = 1'b0;
    in_memop = 3'd0;
    for (int j = 0; j < 64; j++)
      ref_mem[j] = 8'(init_word(j / 4) >> (8 * (j % 4)));
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    set_cfg(1'b1, 0, 0, 0);
    issue(32'h80000003, $urandom, 1'b0, 3'b000);
    issue(32'h80000003, $urandom, 1'b0, 3'b100);
    issue(32'h80000002, $urandom, 1'b0, 3'b001);
    issue(32'h80000000, $urandom, 1'b0, 3'b010);
    issue(32'h80000002, 32'h1234ABCD, 1'b1, 3'b001);
    issue(32'h80000001, 32'h000000EE, 1'b1, 3'b000);
    issue(32'h80000000, $urandom, 1'b0, 3'b010);

    issue(32'h80000001, $urandom, 1'b0, 3'b010);
    issue(32'h80000000, $urandom, 1'b0, 3'b011);
    issue(32'h80000002, $urandom, 1'b1, 3'b100);
    issue(32'h80000003, $urandom, 1'b0, 3'b001);
    issue(32'h80000006, $urandom, 1'b0, 3'b101);

    set_cfg(1'b0, 3, 5, 2);
    issue(32'h80000004, $urandom, 1'b0, 3'b010);
    issue(32'h8000000C, $urandom, 1'b1, 3'b010);
    issue(32'h8000000C, $urandom, 1'b0, 3'b001);

    set_cfg(1'b1, 0, 0, 0);
    lat_mode = 1'b1;
    prev_hs = -1;
    for (int n = 0; n < 6; n++)
      issue(32'h80000000 + 32'($urandom_range(0, 15) * 4), $urandom,
            1'b0, 3'b010);
    lat_mode = 1'b0;

    set_cfg(1'b0, 0, 5, 0);
    abort_mode = 1'b1;
    issue(32'h80000008, $urandom, 1'b0, 3'b010);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (mem_rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("resp_state_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    for (int t = 0; t < 16; t++) begin
      @(negedge clk);
      chk("stale_rsp", 32'({out_valid, mem_rsp_ready}), 32'd0);
    end
    abort_mode = 1'b0;

    for (int n = 0; n < 150; n++) begin
      set_cfg($urandom_range(0, 3) == 0, $urandom_range(0, 2),
              $urandom_range(0, 3), $urandom_range(0, 2));
      if ($urandom_range(0, 9) < 9) begin
        case ($urandom_range(0, 4))
          0: op = 3'b000;
          1: op = 3'b001;
          2: op = 3'b010;
          3: op = 3'b100;
          default: op = 3'b101;
        endcase
      end else begin
        op = 3'($urandom_range(0, 2) == 0 ? 3 :
                ($urandom_range(0, 1) == 0 ? 6 : 7));
      end
      wr = 1'($urandom_range(0, 1));
      if (op[2] && $urandom_range(0, 3) != 0) wr = 1'b0;
      sz = sz_of(op);
      off = $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) off = off & ~(sz - 1);
      issue(32'h80000000 + 32'(off), $urandom, wr, op);
    end

    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("drain_timeout");
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
